io_tick_generator: RTL and testbench
====================================

IO_TICK_GENERATOR -- requirements
Module: io_tick_generator

Interface
REQ-001 SHALL have parameter DATABITWIDTH, default 16, giving the command/writeback data width; must be at least 16.
REQ-002 SHALL have parameter CHANNELCOUNT, default 4, giving the number of tick channels (2..16, power of 2).
REQ-003 SHALL have parameter DIVBITWIDTH, default 14, giving the divisor width per channel (1..14).
REQ-004 SHALL provide ports, clock and reset first:
- clk  in  1  sole clock. One clock domain; reset is synchronous and active-low.
- sync_rst_n  in  1  synchronous active-low reset.
- clk_en  in  1  global advance enable.
- CommandACK  in  1  command valid.
- CommandREQ  out  1  command ready.
- MinorOpcodeIn  in  4  bit2=0 load (readback), bit2=1 store (config write); bit3 = align flag.
- CommandAddressIn_Offset  in  DATABITWIDTH  [log2(CHANNELCOUNT)-1:0] selects the channel.
- CommandDataIn  in  DATABITWIDTH  store: config word.
- CommandDestReg  in  4  load: destination register tag.
- WritebackACK  out  CHANNELCOUNT  per-channel response valid.
- WritebackREQ  in  CHANNELCOUNT  per-channel response ready.
- WritebackDestReg  out  CHANNELCOUNT x 4  response tag.
- WritebackDataOut  out  CHANNELCOUNT x DATABITWIDTH  response data.
- tick_out  out  CHANNELCOUNT  one-cycle strobe per channel.
- level_out  out  CHANNELCOUNT  square-wave level per channel.

Function
REQ-005 SHALL fix the config word layout: [DIVBITWIDTH-1:0] = divisor N; [15:14] = mode (00 off, 01 periodic, 10 one-shot, 11 square); the remaining bits are stored and read back unchanged.
REQ-006 SHALL transfer a command only on a cycle where CommandACK, CommandREQ and clk_en are all 1.
REQ-007 SHALL drive CommandREQ as follows: for a store, 1; for a load, the negation of the selected channel's response-slot-full flag.
REQ-008 SHALL make a store take effect one cycle after transfer: config register written, channel counter cleared to 0, tick_out and level_out of that channel forced to 0 in that cycle.
REQ-009 SHALL, in periodic mode, advance the counter 0..N on each clk_en cycle and assert tick_out for exactly one cycle when the counter equals N, wrapping to 0. Period is N+1 cycles; N=0 gives tick_out constantly high.
REQ-010 SHALL, in square mode, toggle level_out each time the counter wraps, giving period 2(N+1); tick_out pulses on every toggle.
REQ-011 SHALL, in one-shot mode, pulse tick_out once when the counter reaches N, then hardware-clear mode to 00; readback then reports 00.
REQ-012 SHALL, in off mode, hold the counter, tick_out=0 and level_out at its last value.
REQ-013 SHALL hold all counters, outputs and handshakes in place while clk_en=0 (tick_out deasserted).
REQ-014 SHALL, on a load, fill the channel's single-entry response slot one cycle after transfer with {config word, CommandDestReg}; WritebackACK is asserted until a cycle with WritebackREQ=1 and clk_en=1.
REQ-015 SHALL return the post-update value when a load and a one-shot self-clear coincide on the same channel.
REQ-016 SHALL apply a store arriving on the same cycle as a wrap: the store wins, the counter is cleared and no tick is emitted.

Reset
REQ-017 SHALL, on sync_rst_n=0 at a clk edge, clear all configs to 0 (mode off), counters to 0, tick_out, level_out and WritebackACK to 0, response slots to empty, and WritebackDataOut/DestReg to 0.
REQ-018 SHALL let reset override clk_en and in-flight handshakes; a response pending at reset is discarded.

Configuration
REQ-019 SHALL, when IOTICK_PHASE_ALIGN_EN is defined, treat a store with MinorOpcodeIn[3]=1 as an align command: every channel i with CommandDataIn[i]=1 clears its counter and level_out in the same cycle, configs unchanged.
REQ-020 SHALL, when IOTICK_PHASE_ALIGN_EN is undefined, ignore MinorOpcodeIn[3] so that such stores act as ordinary config writes.

Structure
REQ-021 SHALL place the mode enum, config-word field positions and opcode bit indices in the shared package io_pkg.
REQ-022 SHALL implement one channel (counter, mode logic, response slot) as sub-module io_tick_channel, instantiated CHANNELCOUNT times via generate.

Verification
REQ-023 SHALL cover: store ch1 mode 01 N=3 -> tick_out[1] high every 4th cycle starting 4 cycles after the config takes effect.
REQ-024 SHALL cover: store ch2 mode 11 N=1 -> level_out[2] period 4 cycles, 50% duty.
REQ-025 SHALL cover: store ch0 mode 10 N=5 -> exactly one tick at cycle 6; a load then returns 0x0005 with the tag.
REQ-026 SHALL cover: two loads to ch3 with WritebackREQ[3]=0 -> second load sees CommandREQ=0 until drained.
REQ-027 SHALL cover: clk_en low 10 cycles mid-period -> tick phase is delayed by exactly 10 cycles.
REQ-028 SHALL cover, with IOTICK_PHASE_ALIGN_EN: ch0 and ch1 periodic N=7 out of phase, then align data 0x0003 -> identical tick timing thereafter.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the tick generator: channel modes, config-word
// field positions and command opcode bit indices.
package io_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_SQUARE   = 2'b11
    } tick_mode_e;

    localparam int CFG_MODE_LSB = 14;
    localparam int CFG_MODE_MSB = 15;
    localparam int OP_STORE_BIT = 2;
    localparam int OP_ALIGN_BIT = 3;
    localparam int TAG_W        = 4;

endpackage

// File: rtl/io_tick_channel.sv
// One tick channel: config register, divisor counter, mode logic and a
// single-entry readback slot.
module io_tick_channel
    import io_pkg::*;
#(
    parameter int DATABITWIDTH = 16,
    parameter int DIVBITWIDTH  = 14
) (
    input  logic                    clk,
    input  logic                    sync_rst_n,
    input  logic                    clk_en,
    input  logic                    store,
    input  logic                    load,
    input  logic                    align,
    input  logic [DATABITWIDTH-1:0] cmd_data,
    input  logic [TAG_W-1:0]        cmd_tag,
    input  logic                    wb_req,
    output logic                    slot_full,
    output logic [TAG_W-1:0]        wb_tag,
    output logic [DATABITWIDTH-1:0] wb_data,
    output logic                    tick,
    output logic                    level
);

    logic [DATABITWIDTH-1:0] cfg, cfg_next;
    logic [DIVBITWIDTH-1:0]  cnt, cnt_next, div;
    logic                    tick_next, level_next, wrap;
    tick_mode_e              mode;

    assign div  = cfg[DIVBITWIDTH-1:0];
    assign mode = tick_mode_e'(cfg[CFG_MODE_MSB:CFG_MODE_LSB]);
    assign wrap = (cnt == div);

    // store/align only reach here on clk_en cycles, and take priority over a wrap
    always_comb begin
        cfg_next   = cfg;
        cnt_next   = cnt;
        tick_next  = 1'b0;
        level_next = level;
        if (store) begin
            cfg_next   = cmd_data;
            cnt_next   = '0;
            level_next = 1'b0;
        end else if (align) begin
            cnt_next   = '0;
            level_next = 1'b0;
        end else if (clk_en && mode != MODE_OFF) begin
            cnt_next  = wrap ? '0 : cnt + 1'b1;
            tick_next = wrap;
            if (wrap && mode == MODE_SQUARE)
                level_next = ~level;
            if (wrap && mode == MODE_ONESHOT)
                cfg_next[CFG_MODE_MSB:CFG_MODE_LSB] = MODE_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            cfg       <= '0;
            cnt       <= '0;
            tick      <= 1'b0;
            level     <= 1'b0;
            slot_full <= 1'b0;
            wb_tag    <= '0;
            wb_data   <= '0;
        end else begin
            cfg   <= cfg_next;
            cnt   <= cnt_next;
            tick  <= tick_next;
            level <= level_next;
            // readback captures cfg_next so a coincident one-shot clear is visible
            if (load) begin
                slot_full <= 1'b1;
                wb_data   <= cfg_next;
                wb_tag    <= cmd_tag;
            end else if (slot_full && wb_req && clk_en) begin
                slot_full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/io_tick_generator.sv
// Multi-channel programmable tick/square-wave generator with a load/store
// command port. Optional phase-align command: IOTICK_PHASE_ALIGN_EN.
module io_tick_generator
    import io_pkg::*;
#(
    parameter int DATABITWIDTH = 16,
    parameter int CHANNELCOUNT = 4,
    parameter int DIVBITWIDTH  = 14
) (
    input  logic                                       clk,
    input  logic                                       sync_rst_n,
    input  logic                                       clk_en,
    input  logic                                       CommandACK,
    output logic                                       CommandREQ,
    input  logic [3:0]                                 MinorOpcodeIn,
    input  logic [DATABITWIDTH-1:0]                    CommandAddressIn_Offset,
    input  logic [DATABITWIDTH-1:0]                    CommandDataIn,
    input  logic [TAG_W-1:0]                           CommandDestReg,
    output logic [CHANNELCOUNT-1:0]                    WritebackACK,
    input  logic [CHANNELCOUNT-1:0]                    WritebackREQ,
    output logic [CHANNELCOUNT-1:0][TAG_W-1:0]         WritebackDestReg,
    output logic [CHANNELCOUNT-1:0][DATABITWIDTH-1:0]  WritebackDataOut,
    output logic [CHANNELCOUNT-1:0]                    tick_out,
    output logic [CHANNELCOUNT-1:0]                    level_out
);

    localparam int SELW = $clog2(CHANNELCOUNT);

    logic [SELW-1:0] sel;
    logic            is_op_store, xfer, cfg_store, is_load, is_align;
    logic            unused_ok;

    assign sel         = CommandAddressIn_Offset[SELW-1:0];
    assign is_op_store = MinorOpcodeIn[OP_STORE_BIT];
    assign CommandREQ  = is_op_store ? 1'b1 : ~WritebackACK[sel];
    assign xfer        = CommandACK & CommandREQ & clk_en;
    assign is_load     = xfer & ~is_op_store;

`ifdef IOTICK_PHASE_ALIGN_EN
    assign is_align  = xfer & is_op_store & MinorOpcodeIn[OP_ALIGN_BIT];
    assign cfg_store = xfer & is_op_store & ~MinorOpcodeIn[OP_ALIGN_BIT];
    assign unused_ok = ^{CommandAddressIn_Offset[DATABITWIDTH-1:SELW], MinorOpcodeIn[1:0]};
`else
    assign is_align  = 1'b0;
    assign cfg_store = xfer & is_op_store;
    assign unused_ok = ^{CommandAddressIn_Offset[DATABITWIDTH-1:SELW], MinorOpcodeIn[3],
                         MinorOpcodeIn[1:0]};
`endif

    for (genvar i = 0; i < CHANNELCOUNT; i++) begin : g_ch
        localparam logic [SELW-1:0] CH = SELW'(i);
        io_tick_channel #(
            .DATABITWIDTH(DATABITWIDTH),
            .DIVBITWIDTH (DIVBITWIDTH)
        ) u_ch (
            .clk       (clk),
            .sync_rst_n(sync_rst_n),
            .clk_en    (clk_en),
            .store     (cfg_store && sel == CH),
            .load      (is_load && sel == CH),
            .align     (is_align && CommandDataIn[i]),
            .cmd_data  (CommandDataIn),
            .cmd_tag   (CommandDestReg),
            .wb_req    (WritebackREQ[i]),
            .slot_full (WritebackACK[i]),
            .wb_tag    (WritebackDestReg[i]),
            .wb_data   (WritebackDataOut[i]),
            .tick      (tick_out[i]),
            .level     (level_out[i])
        );
    end

endmodule

// File: tb/tb_io_tick_generator.sv
// Directed self-checking bench for io_tick_generator (default parameters).
module tb_io_tick_generator;
    import io_pkg::*;

    localparam int DW = 16;
    localparam int CC = 4;

    logic                       clk = 1'b0;
    logic                       sync_rst_n;
    logic                       clk_en;
    logic                       CommandACK;
    logic                       CommandREQ;
    logic [3:0]                 MinorOpcodeIn;
    logic [DW-1:0]              CommandAddressIn_Offset;
    logic [DW-1:0]              CommandDataIn;
    logic [3:0]                 CommandDestReg;
    logic [CC-1:0]              WritebackACK;
    logic [CC-1:0]              WritebackREQ;
    logic [CC-1:0][3:0]         WritebackDestReg;
    logic [CC-1:0][DW-1:0]      WritebackDataOut;
    logic [CC-1:0]              tick_out;
    logic [CC-1:0]              level_out;

    int total = 0;
    int bad   = 0;

    io_tick_generator #(.DATABITWIDTH(DW), .CHANNELCOUNT(CC), .DIVBITWIDTH(14)) dut (
        .clk                    (clk),
        .sync_rst_n             (sync_rst_n),
        .clk_en                 (clk_en),
        .CommandACK             (CommandACK),
        .CommandREQ             (CommandREQ),
        .MinorOpcodeIn          (MinorOpcodeIn),
        .CommandAddressIn_Offset(CommandAddressIn_Offset),
        .CommandDataIn          (CommandDataIn),
        .CommandDestReg         (CommandDestReg),
        .WritebackACK           (WritebackACK),
        .WritebackREQ           (WritebackREQ),
        .WritebackDestReg       (WritebackDestReg),
        .WritebackDataOut       (WritebackDataOut),
        .tick_out               (tick_out),
        .level_out              (level_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input int ch, input logic [15:0] data, input logic [3:0] op);
        CommandACK              = 1'b1;
        MinorOpcodeIn           = op;
        CommandAddressIn_Offset = DW'(ch);
        CommandDataIn           = data;
        step();
        CommandACK              = 1'b0;
    endtask

    task automatic test_reset();
        sync_rst_n = 1'b0;
        clk_en     = 1'b0;
        repeat (3) step();
        MinorOpcodeIn = 4'b0000;
        CommandAddressIn_Offset = '0;
        if ({tick_out, level_out, WritebackACK} !== '0) begin
            bad++; $display("FAIL reset_outs got=%h want=0", {tick_out, level_out, WritebackACK});
        end
        total++;
        if ({WritebackDataOut, WritebackDestReg} !== '0) begin
            bad++; $display("FAIL reset_wb got=%h want=0", {WritebackDataOut, WritebackDestReg});
        end
        total++;
        if (CommandREQ !== 1'b1) begin
            bad++; $display("FAIL reset_req got=%b want=1", CommandREQ);
        end
        total++;
        sync_rst_n = 1'b1;
        clk_en     = 1'b1;
        step();
    endtask

    task automatic test_periodic();
        do_store(1, 16'h4003, 4'b0100);
        if (tick_out[1] !== 1'b0) begin
            bad++; $display("FAIL periodic_start got=%b want=0", tick_out[1]);
        end
        total++;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (tick_out[1] !== (k % 4 == 0)) begin
                bad++; $display("FAIL periodic k=%0d got=%b want=%b", k, tick_out[1], (k % 4 == 0));
            end
            total++;
        end
    endtask

    task automatic test_store_wins();
        do_store(1, 16'h4003, 4'b0100);
        repeat (3) step();
        do_store(1, 16'h4003, 4'b0100);
        if (tick_out[1] !== 1'b0) begin
            bad++; $display("FAIL store_wins got=%b want=0", tick_out[1]);
        end
        total++;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (tick_out[1] !== (k == 4)) begin
                bad++; $display("FAIL store_wins k=%0d got=%b want=%b", k, tick_out[1], (k == 4));
            end
            total++;
        end
    endtask

    task automatic test_square();
        do_store(2, 16'hC001, 4'b0100);
        for (int k = 1; k <= 8; k++) begin
            step();
            if (level_out[2] !== (k % 4 >= 2)) begin
                bad++; $display("FAIL square_level k=%0d got=%b want=%b", k, level_out[2], (k % 4 >= 2));
            end
            total++;
            if (tick_out[2] !== (k % 2 == 0)) begin
                bad++; $display("FAIL square_tick k=%0d got=%b want=%b", k, tick_out[2], (k % 2 == 0));
            end
            total++;
        end
    endtask

    task automatic test_oneshot();
        do_store(0, 16'h8005, 4'b0100);
        for (int k = 1; k <= 10; k++) begin
            step();
            if (tick_out[0] !== (k == 6)) begin
                bad++; $display("FAIL oneshot k=%0d got=%b want=%b", k, tick_out[0], (k == 6));
            end
            total++;
        end
        CommandACK = 1'b1; MinorOpcodeIn = 4'b0000; CommandAddressIn_Offset = 0; CommandDestReg = 4'hA;
        if (CommandREQ !== 1'b1) begin
            bad++; $display("FAIL oneshot_req got=%b want=1", CommandREQ);
        end
        total++;
        step();
        CommandACK = 1'b0;
        if (WritebackACK[0] !== 1'b1 || WritebackDataOut[0] !== 16'h0005 || WritebackDestReg[0] !== 4'hA) begin
            bad++; $display("FAIL oneshot_load ack=%b data=%h tag=%h want 1/0005/a",
                            WritebackACK[0], WritebackDataOut[0], WritebackDestReg[0]);
        end
        total++;
        WritebackREQ[0] = 1'b1;
        step();
        WritebackREQ[0] = 1'b0;
        if (WritebackACK[0] !== 1'b0) begin
            bad++; $display("FAIL oneshot_drain got=%b want=0", WritebackACK[0]);
        end
        total++;
    endtask

    task automatic test_load_clear_collide();
        do_store(0, 16'h8002, 4'b0100);
        repeat (2) step();
        CommandACK = 1'b1; MinorOpcodeIn = 4'b0000; CommandAddressIn_Offset = 0; CommandDestReg = 4'h5;
        step();
        CommandACK = 1'b0;
        if (tick_out[0] !== 1'b1 || WritebackDataOut[0] !== 16'h0002 || WritebackDestReg[0] !== 4'h5) begin
            bad++; $display("FAIL collide tick=%b data=%h tag=%h want 1/0002/5",
                            tick_out[0], WritebackDataOut[0], WritebackDestReg[0]);
        end
        total++;
        WritebackREQ[0] = 1'b1;
        step();
        WritebackREQ[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        WritebackREQ = '0;
        CommandACK = 1'b1; MinorOpcodeIn = 4'b0000; CommandAddressIn_Offset = 3; CommandDestReg = 4'h1;
        if (CommandREQ !== 1'b1) begin
            bad++; $display("FAIL b2b_req1 got=%b want=1", CommandREQ);
        end
        total++;
        step();
        CommandDestReg = 4'h2;
        for (int k = 0; k < 4; k++) begin
            if (CommandREQ !== 1'b0 || WritebackACK[3] !== 1'b1 || WritebackDestReg[3] !== 4'h1) begin
                bad++; $display("FAIL b2b_stall k=%0d req=%b ack=%b tag=%h want 0/1/1",
                                k, CommandREQ, WritebackACK[3], WritebackDestReg[3]);
            end
            total++;
            step();
        end
        // the cycle of the last loop iteration had WritebackREQ low; now drain
        WritebackREQ[3] = 1'b1;
        step();
        if (WritebackACK[3] !== 1'b0 || CommandREQ !== 1'b1) begin
            bad++; $display("FAIL b2b_drain ack=%b req=%b want 0/1", WritebackACK[3], CommandREQ);
        end
        total++;
        WritebackREQ[3] = 1'b0;
        step();
        CommandACK = 1'b0;
        if (WritebackACK[3] !== 1'b1 || WritebackDestReg[3] !== 4'h2 || WritebackDataOut[3] !== 16'h0000) begin
            bad++; $display("FAIL b2b_second ack=%b tag=%h data=%h want 1/2/0000",
                            WritebackACK[3], WritebackDestReg[3], WritebackDataOut[3]);
        end
        total++;
        WritebackREQ[3] = 1'b1;
        step();
        WritebackREQ[3] = 1'b0;
        if (WritebackACK[3] !== 1'b0) begin
            bad++; $display("FAIL b2b_final got=%b want=0", WritebackACK[3]);
        end
        total++;
    endtask

    task automatic test_clk_en();
        do_store(1, 16'h4003, 4'b0100);
        for (int k = 1; k <= 5; k++) begin
            step();
            if (tick_out[1] !== (k == 4)) begin
                bad++; $display("FAIL clken_pre k=%0d got=%b want=%b", k, tick_out[1], (k == 4));
            end
            total++;
        end
        clk_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (tick_out[1] !== 1'b0) begin
                bad++; $display("FAIL clken_hold k=%0d got=%b want=0", k, tick_out[1]);
            end
            total++;
        end
        clk_en = 1'b1;
        for (int k = 6; k <= 13; k++) begin
            step();
            if (tick_out[1] !== (k % 4 == 0)) begin
                bad++; $display("FAIL clken_post k=%0d got=%b want=%b", k, tick_out[1], (k % 4 == 0));
            end
            total++;
        end
    endtask

`ifdef IOTICK_PHASE_ALIGN_EN
    task automatic test_align();
        do_store(0, 16'h4007, 4'b0100);
        repeat (3) step();
        do_store(1, 16'h4007, 4'b0100);
        for (int k = 1; k <= 4; k++) begin
            step();
            if (tick_out[0] !== (k == 4) || tick_out[1] !== 1'b0) begin
                bad++; $display("FAIL align_pre k=%0d got=%b%b want=%b0", k, tick_out[0], tick_out[1], (k == 4));
            end
            total++;
        end
        do_store(0, 16'h0003, 4'b1100);
        for (int k = 1; k <= 16; k++) begin
            step();
            if (tick_out[0] !== (k % 8 == 0) || tick_out[1] !== (k % 8 == 0)) begin
                bad++; $display("FAIL align k=%0d got=%b%b want=%b", k, tick_out[0], tick_out[1], (k % 8 == 0));
            end
            total++;
        end
        CommandACK = 1'b1; MinorOpcodeIn = 4'b0000; CommandAddressIn_Offset = 0; CommandDestReg = 4'h7;
        step();
        CommandACK = 1'b0;
        if (WritebackDataOut[0] !== 16'h4007) begin
            bad++; $display("FAIL align_cfg got=%h want=4007", WritebackDataOut[0]);
        end
        total++;
        WritebackREQ[0] = 1'b1;
        step();
        WritebackREQ[0] = 1'b0;
    endtask
`else
    task automatic test_align();
        do_store(0, 16'h4003, 4'b1100);
        for (int k = 1; k <= 4; k++) begin
            step();
            if (tick_out[0] !== (k == 4)) begin
                bad++; $display("FAIL noalign k=%0d got=%b want=%b", k, tick_out[0], (k == 4));
            end
            total++;
        end
        CommandACK = 1'b1; MinorOpcodeIn = 4'b0000; CommandAddressIn_Offset = 0; CommandDestReg = 4'h7;
        step();
        CommandACK = 1'b0;
        if (WritebackDataOut[0] !== 16'h4003) begin
            bad++; $display("FAIL noalign_cfg got=%h want=4003", WritebackDataOut[0]);
        end
        total++;
        WritebackREQ[0] = 1'b1;
        step();
        WritebackREQ[0] = 1'b0;
    endtask
`endif

    task automatic test_reset_inflight();
        CommandACK = 1'b1; MinorOpcodeIn = 4'b0000; CommandAddressIn_Offset = 3; CommandDestReg = 4'h9;
        step();
        CommandACK = 1'b0;
        if (WritebackACK[3] !== 1'b1) begin
            bad++; $display("FAIL inflight_pending got=%b want=1", WritebackACK[3]);
        end
        total++;
        clk_en = 1'b0;
        sync_rst_n = 1'b0;
        step();
        if (WritebackACK !== '0 || WritebackDataOut[3] !== '0 || WritebackDestReg[3] !== '0
            || tick_out !== '0 || level_out !== '0) begin
            bad++; $display("FAIL inflight_reset ack=%b data=%h tag=%h tick=%b lvl=%b want all 0",
                            WritebackACK, WritebackDataOut[3], WritebackDestReg[3], tick_out, level_out);
        end
        total++;
        sync_rst_n = 1'b1;
        clk_en = 1'b1;
        step();
    endtask

    initial begin
        sync_rst_n = 1'b0; clk_en = 1'b0; CommandACK = 1'b0; MinorOpcodeIn = '0;
        CommandAddressIn_Offset = '0; CommandDataIn = '0; CommandDestReg = '0; WritebackREQ = '0;
        test_reset();
        test_periodic();
        test_store_wins();
        test_square();
        test_oneshot();
        test_load_clear_collide();
        test_back_to_back();
        test_clk_en();
        test_align();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
